// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the 2x2 systolic operand feeder
package systolic_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int N              = 2;
    localparam int FEED_CYCLES    = 3;
    localparam int DRAIN_CYCLES   = 2;
    localparam int NUM_OPS        = 2 * N * N;

    localparam logic [1:0] FEED_LAST  = 2'(FEED_CYCLES - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    // Slot order inside an operand set: A row-major, then B row-major
    localparam int OP_A00 = 0;
    localparam int OP_A01 = 1;
    localparam int OP_A10 = 2;
    localparam int OP_A11 = 3;
    localparam int OP_B00 = 4;
    localparam int OP_B01 = 5;
    localparam int OP_B10 = 6;
    localparam int OP_B11 = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/systolic_operand_buf.sv
// rtl/systolic_operand_buf.sv - eight-operand register set with load and synchronous clear
module systolic_operand_buf
    import systolic_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      clear,
    input  logic [NUM_OPS-1:0][W-1:0] d,
    output logic [NUM_OPS-1:0][W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// rtl/systolic_feeder_2x2.sv - skewed A/B edge feeder for a 2x2 systolic array
// FEEDER_DOUBLE_BUF_EN adds a shadow operand set so back-to-back jobs overlap.
module systolic_feeder_2x2
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1,
    output logic              feed_valid,
    output logic              clear_acc,
    output logic              done
);

    feeder_state_t state, state_nxt;
    logic [1:0] k, k_nxt;

    logic [NUM_OPS-1:0][DATA_W-1:0] ops_in, act_d, act_q;
    logic accept, start, act_clear;
    logic [DATA_W-1:0] row0_nxt, row1_nxt, col0_nxt, col1_nxt;

    assign ops_in = {b11, b10, b01, b00, a11, a10, a01, a00};
    assign accept = in_valid && in_ready;

`ifdef FEEDER_DOUBLE_BUF_EN
    logic shd_full, to_shadow, shd_clear;
    logic [NUM_OPS-1:0][DATA_W-1:0] shd_q;

    // Anything accepted outside IDLE waits in the shadow until the active job ends
    assign in_ready  = !shd_full;
    assign to_shadow = accept && (state != ST_IDLE);
    assign start     = ((state == ST_IDLE) && (shd_full || accept)) ||
                       ((state == ST_DONE) && shd_full);
    assign act_d     = shd_full ? shd_q : ops_in;
    assign shd_clear = start && shd_full && !to_shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shd_full <= 1'b0;
        end else begin
            shd_full <= to_shadow || (shd_full && !start);
        end
    end

    systolic_operand_buf #(.W(DATA_W)) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .load  (to_shadow),
        .clear (shd_clear),
        .d     (ops_in),
        .q     (shd_q)
    );
`else
    logic ready_q;

    assign in_ready = ready_q;
    assign start    = accept;
    assign act_d    = ops_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= (state_nxt == ST_IDLE);
        end
    end
`endif

    assign act_clear = (state == ST_DONE) && !start;

    systolic_operand_buf #(.W(DATA_W)) u_active (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .clear (act_clear),
        .d     (act_d),
        .q     (act_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        row0_nxt  = '0;
        row1_nxt  = '0;
        col0_nxt  = '0;
        col1_nxt  = '0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                state_nxt = ST_FEED;
                k_nxt     = '0;
            end
            ST_FEED: begin
                if (k == FEED_LAST) begin
                    state_nxt = ST_DRAIN;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (k == DRAIN_LAST) begin
                    state_nxt = ST_DONE;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 2'd1;
                end
            end
            ST_DONE:  state_nxt = start ? ST_CLEAR : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Lanes are precomputed for the upcoming cycle so every output is a flop
        if (state_nxt == ST_FEED) begin
            case (k_nxt)
                2'd0: begin
                    row0_nxt = act_q[OP_A00];
                    col0_nxt = act_q[OP_B00];
                end
                2'd1: begin
                    row0_nxt = act_q[OP_A01];
                    row1_nxt = act_q[OP_A10];
                    col0_nxt = act_q[OP_B10];
                    col1_nxt = act_q[OP_B01];
                end
                2'd2: begin
                    row1_nxt = act_q[OP_A11];
                    col1_nxt = act_q[OP_B11];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_row0     <= '0;
            a_row1     <= '0;
            b_col0     <= '0;
            b_col1     <= '0;
            feed_valid <= 1'b0;
            clear_acc  <= 1'b0;
            done       <= 1'b0;
        end else begin
            a_row0     <= row0_nxt;
            a_row1     <= row1_nxt;
            b_col0     <= col0_nxt;
            b_col1     <= col1_nxt;
            feed_valid <= (state_nxt == ST_FEED);
            clear_acc  <= (state_nxt == ST_CLEAR);
            done       <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// tb/tb_systolic_feeder_2x2.sv - directed self-checking bench for systolic_feeder_2x2
module tb_systolic_feeder_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11;
    logic [31:0] a_row0, a_row1, b_col0, b_col1;
    logic        feed_valid, clear_acc, done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [31:0] acc [4];
    logic [31:0] pr0, pr1, pc0, pc1;

    always #5 clk = ~clk;

    systolic_feeder_2x2 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a00        (a00),
        .a01        (a01),
        .a10        (a10),
        .a11        (a11),
        .b00        (b00),
        .b01        (b01),
        .b10        (b10),
        .b11        (b11),
        .a_row0     (a_row0),
        .a_row1     (a_row1),
        .b_col0     (b_col0),
        .b_col1     (b_col1),
        .feed_valid (feed_valid),
        .clear_acc  (clear_acc),
        .done       (done)
    );

    // Reference 2x2 output-stationary array fed by the DUT lanes
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (clear_acc) begin
            for (int i = 0; i < 4; i++) acc[i] = '0;
            pr0 = '0; pr1 = '0; pc0 = '0; pc1 = '0;
        end else begin
            acc[0] = acc[0] + a_row0 * b_col0;
            acc[1] = acc[1] + pr0 * b_col1;
            acc[2] = acc[2] + a_row1 * pc0;
            acc[3] = acc[3] + pr1 * pc1;
            pr0 = a_row0; pr1 = a_row1; pc0 = b_col0; pc1 = b_col1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
        a00 = a[0]; a01 = a[1]; a10 = a[2]; a11 = a[3];
        b00 = b[0]; b01 = b[1]; b10 = b[2]; b11 = b[3];
    endtask

    task automatic accept_job();
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Entered one step after the accepting edge; leaves in the done cycle
    task automatic check_sched(input string tag, input logic [3:0][31:0] a,
                               input logic [3:0][31:0] b, input logic [3:0][31:0] c);
        logic [31:0] er0 [3];
        logic [31:0] er1 [3];
        logic [31:0] ec0 [3];
        logic [31:0] ec1 [3];
        er0[0] = a[0]; er0[1] = a[1]; er0[2] = '0;
        er1[0] = '0;   er1[1] = a[2]; er1[2] = a[3];
        ec0[0] = b[0]; ec0[1] = b[2]; ec0[2] = '0;
        ec1[0] = '0;   ec1[1] = b[1]; ec1[2] = b[3];
        check_eq($sformatf("%s_clear", tag), 32'(clear_acc), 32'd1);
        check_eq($sformatf("%s_clear_fv", tag), 32'(feed_valid), 32'd0);
        check_eq($sformatf("%s_clear_lanes", tag), a_row0 | a_row1 | b_col0 | b_col1, 32'd0);
`ifndef FEEDER_DOUBLE_BUF_EN
        check_eq($sformatf("%s_busy_ready", tag), 32'(in_ready), 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("%s_k%0d_fv", tag, k), 32'(feed_valid), 32'd1);
            check_eq($sformatf("%s_k%0d_clr", tag, k), 32'(clear_acc), 32'd0);
            check_eq($sformatf("%s_k%0d_row0", tag, k), a_row0, er0[k]);
            check_eq($sformatf("%s_k%0d_row1", tag, k), a_row1, er1[k]);
            check_eq($sformatf("%s_k%0d_col0", tag, k), b_col0, ec0[k]);
            check_eq($sformatf("%s_k%0d_col1", tag, k), b_col1, ec1[k]);
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            check_eq($sformatf("%s_drain%0d_fv", tag, d), 32'(feed_valid), 32'd0);
            check_eq($sformatf("%s_drain%0d_lanes", tag, d), a_row0 | a_row1 | b_col0 | b_col1, 32'd0);
            check_eq($sformatf("%s_drain%0d_done", tag, d), 32'(done), 32'd0);
        end
        tick();
        check_eq($sformatf("%s_done", tag), 32'(done), 32'd1);
        check_eq($sformatf("%s_done_fv", tag), 32'(feed_valid | clear_acc), 32'd0);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_c%0d", tag, i), acc[i], c[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] am, bm, a3, b1, af, cm, c6, c2;
        logic [31:0] idle_or;
        int d0;
        am = {32'd2, 32'd0, 32'd2, 32'd1};
        bm = {32'd2, 32'd0, 32'd2, 32'd1};
        cm = {32'd4, 32'd0, 32'd6, 32'd1};
        a3 = {4{32'd3}};
        b1 = {4{32'd1}};
        c6 = {4{32'd6}};
        af = {4{32'hFFFF_FFFF}};
        c2 = {4{32'd2}};

        rst = 1'b0;
        in_valid = 1'b0;
        set_ops('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", a_row0 | a_row1 | b_col0 | b_col1, 32'd0);
        check_eq("rst_flags", {29'd0, feed_valid, clear_acc, done}, 32'd0);
        rst = 1'b1;
        tick();
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);

        set_ops(am, bm);
        in_valid = 1'b1;
        accept_job();
        check_sched("single", am, bm, cm);
        tick();
        check_eq("single_after_done", 32'(done), 32'd0);
        check_eq("single_after_ready", 32'(in_ready), 32'd1);

`ifndef FEEDER_DOUBLE_BUF_EN
        set_ops(am, bm);
        in_valid = 1'b1;
        accept_job();
        set_ops(a3, b1);
        in_valid = 1'b1;
        check_sched("bp_first", am, bm, cm);
        tick();
        check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp_not_yet", 32'(clear_acc), 32'd0);
        accept_job();
        check_sched("bp_second", a3, b1, c6);
        tick();
`else
        set_ops(am, bm);
        in_valid = 1'b1;
        accept_job();
        set_ops(a3, b1);
        in_valid = 1'b1;
        fork
            check_sched("b2b_first", am, bm, cm);
            begin
                tick();
                in_valid = 1'b0;
            end
        join
        tick();
        check_sched("b2b_second", a3, b1, c6);
        tick();
`endif

        set_ops(af, af);
        in_valid = 1'b1;
        accept_job();
        check_sched("maxval", af, af, c2);
        tick();

        set_ops(am, bm);
        in_valid = 1'b1;
        accept_job();
        tick();
        tick();
        check_eq("rst_mid_feed_active", 32'(feed_valid), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rst_async_lanes", a_row0 | a_row1 | b_col0 | b_col1, 32'd0);
        check_eq("rst_async_flags", {29'd0, feed_valid, clear_acc, done}, 32'd0);
        d0 = done_cnt;
        tick();
        tick();
        rst = 1'b1;
        repeat (12) tick();
        check_eq("rst_no_done", 32'(done_cnt), 32'(d0));
        check_eq("rst_release_ready", 32'(in_ready), 32'd1);

        idle_or = '0;
        repeat (20) begin
            tick();
            idle_or = idle_or | a_row0 | a_row1 | b_col0 | b_col1 |
                      {29'd0, feed_valid, clear_acc, done};
        end
        check_eq("idle_quiet", idle_or, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
